// File: rtl/icache_fill_responder.sv
// Memory-side fill responder for the icache q1/q2 channels: fetches one aligned word
// byte-by-byte over the RAM bus. Define FILL_LAST_WORD_BUF_EN to add a last-word buffer.
module icache_fill_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              q1_valid,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic [31:0]       q1_result,
  output logic              q1_ready,
  input  logic              q2_valid,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic [31:0]       q2_result,
  output logic              q2_ready,
  input  logic              rob_clear,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  if (RAM_LAT != 1) begin : g_lat_check
    $error("icache_fill_responder supports RAM_LAT == 1 only");
  end

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              chan_q, chan_d;     // 0 = q1, 1 = q2
  logic [2:0]        drv_q, drv_d;       // byte index on mem_a; 4 = none
  logic [1:0]        cap_q, cap_d;       // next byte index to capture
  logic              pend_q, pend_d;     // mem_din carries byte cap_q this cycle
  logic [31:0]       word_q, word_d;
  logic              stall_q, stall_d;
  logic              q1_ready_q, q1_ready_d;
  logic              q2_ready_q, q2_ready_d;
  logic [31:0]       q1_result_q, q1_result_d;
  logic [31:0]       q2_result_q, q2_result_d;
`ifdef FILL_LAST_WORD_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_base_q, buf_base_d;
  logic [31:0]       buf_word_q, buf_word_d;
`endif

  logic [ADDR_W-1:0] q1_base, q2_base;
  logic              unused_addr_lsbs;

  assign q1_base          = {q1_addr[ADDR_W-1:2], 2'b00};
  assign q2_base          = {q2_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsbs = ^{q1_addr[1:0], q2_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_a_d     = mem_a_q;
    chan_d      = chan_q;
    drv_d       = drv_q;
    cap_d       = cap_q;
    pend_d      = pend_q;
    word_d      = word_q;
    stall_d     = ~rdy_in;
    q1_ready_d  = q1_ready_q;
    q2_ready_d  = q2_ready_q;
    q1_result_d = q1_result_q;
    q2_result_d = q2_result_q;
`ifdef FILL_LAST_WORD_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_base_d  = buf_base_q;
    buf_word_d  = buf_word_q;
`endif
    if (rdy_in) begin
      q1_ready_d = 1'b0;
      q2_ready_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          mem_a_d = '0;
          if (!rob_clear && (q1_valid || q2_valid)) begin
            chan_d = ~q1_valid;
            base_d = q1_valid ? q1_base : q2_base;
`ifdef FILL_LAST_WORD_BUF_EN
            if (buf_valid_q && (buf_base_q == base_d)) begin
              state_d = DONE;
              word_d  = buf_word_q;
              if (chan_d) begin
                q2_ready_d  = 1'b1;
                q2_result_d = buf_word_q;
              end else begin
                q1_ready_d  = 1'b1;
                q1_result_d = buf_word_q;
              end
            end else begin
              state_d = READ;
              drv_d   = 3'd0;
              cap_d   = 2'd0;
              pend_d  = 1'b0;
              mem_a_d = base_d;
            end
`else
            state_d = READ;
            drv_d   = 3'd0;
            cap_d   = 2'd0;
            pend_d  = 1'b0;
            mem_a_d = base_d;
`endif
          end
        end
        READ: begin
          if (rob_clear) begin
            state_d = IDLE;
            mem_a_d = '0;
            pend_d  = 1'b0;
          end else if (stall_q) begin
            // First cycle after a stall: mem_a shows the oldest uncaptured byte, so
            // treat this cycle as its re-issue and drop whatever arrives on mem_din.
            pend_d  = 1'b1;
            drv_d   = {1'b0, cap_q} + 3'd1;
            mem_a_d = (drv_d == 3'd4) ? '0 : base_q + ADDR_W'(drv_d);
          end else begin
            if (pend_q) begin
              word_d[{cap_q, 3'b000} +: 8] = mem_din;
              cap_d = cap_q + 2'd1;
            end
            pend_d  = (drv_q != 3'd4);
            drv_d   = (drv_q == 3'd4) ? 3'd4 : drv_q + 3'd1;
            mem_a_d = (drv_d == 3'd4) ? '0 : base_q + ADDR_W'(drv_d);
            if (pend_q && (cap_q == 2'd3)) begin
              state_d = DONE;
              mem_a_d = '0;
              pend_d  = 1'b0;
              if (chan_q) begin
                q2_ready_d  = 1'b1;
                q2_result_d = word_d;
              end else begin
                q1_ready_d  = 1'b1;
                q1_result_d = word_d;
              end
`ifdef FILL_LAST_WORD_BUF_EN
              buf_valid_d = 1'b1;
              buf_base_d  = base_q;
              buf_word_d  = word_d;
`endif
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          mem_a_d = '0;
        end
        default: begin
          state_d = IDLE;
          mem_a_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      base_q      <= '0;
      mem_a_q     <= '0;
      chan_q      <= 1'b0;
      drv_q       <= 3'd0;
      cap_q       <= 2'd0;
      pend_q      <= 1'b0;
      word_q      <= '0;
      stall_q     <= 1'b0;
      q1_ready_q  <= 1'b0;
      q2_ready_q  <= 1'b0;
      q1_result_q <= '0;
      q2_result_q <= '0;
`ifdef FILL_LAST_WORD_BUF_EN
      buf_valid_q <= 1'b0;
      buf_base_q  <= '0;
      buf_word_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_a_q     <= mem_a_d;
      chan_q      <= chan_d;
      drv_q       <= drv_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      word_q      <= word_d;
      stall_q     <= stall_d;
      q1_ready_q  <= q1_ready_d;
      q2_ready_q  <= q2_ready_d;
      q1_result_q <= q1_result_d;
      q2_result_q <= q2_result_d;
`ifdef FILL_LAST_WORD_BUF_EN
      buf_valid_q <= buf_valid_d;
      buf_base_q  <= buf_base_d;
      buf_word_q  <= buf_word_d;
`endif
    end
  end

  // While stalled (and on the resume cycle) the bus points at the oldest uncaptured byte.
  assign mem_a     = ((state_q == READ) && (!rdy_in || stall_q)) ? base_q + ADDR_W'(cap_q)
                                                                 : mem_a_q;
  assign q1_ready  = q1_ready_q & rdy_in;
  assign q2_ready  = q2_ready_q & rdy_in;
  assign q1_result = q1_result_q;
  assign q2_result = q2_result_q;
  assign mem_wr    = 1'b0;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder: directed latency/flush/stall/reset cases
// plus randomized two-channel traffic against a byte-array memory model.
module tb_icache_fill_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        q1_valid, q2_valid;
  logic [31:0] q1_addr, q2_addr;
  logic [31:0] q1_result, q2_result;
  logic        q1_ready, q2_ready;
  logic        rob_clear;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_wr;

  localparam int HIT_LAT =
`ifdef FILL_LAST_WORD_BUF_EN
    1;
`else
    6;
`endif

  icache_fill_responder #(.ADDR_W(32), .RAM_LAT(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .q1_valid(q1_valid), .q1_addr(q1_addr), .q1_result(q1_result), .q1_ready(q1_ready),
    .q2_valid(q2_valid), .q2_addr(q2_addr), .q2_result(q2_result), .q2_ready(q2_ready),
    .rob_clear(rob_clear), .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]) + 8'h5B + {a[1:0], 6'd0};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [31:0] b;
    b = addr & 32'hFFFF_FFFC;
    return {ram_byte(b + 32'd3), ram_byte(b + 32'd2), ram_byte(b + 32'd1), ram_byte(b)};
  endfunction

  always @(posedge clk_in) mem_din <= ram_byte(mem_a);

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;
  exp_t q1_exp[$];
  exp_t q2_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] addr, input int due);
    exp_t e;
    e.word = ref_word(addr);
    e.due  = due;
    if (ch == 1) q1_exp.push_back(e);
    else         q2_exp.push_back(e);
  endtask

  // Monitor: pops the per-channel scoreboard on every visible ready pulse.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in) begin
      if (q1_ready || q2_ready) check("ready_exclusive", {31'd0, q1_ready & q2_ready}, 32'd0);
      if (q1_ready) begin
        if (q1_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL q1_spurious_ready: got ready=1 required no pulse (cycle %0d)", cyc);
        end else begin
          e = q1_exp.pop_front();
          check("q1_result", q1_result, e.word);
          if (e.due >= 0) check("q1_ready_cycle", cyc, e.due);
        end
      end
      if (q2_ready) begin
        if (q2_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL q2_spurious_ready: got ready=1 required no pulse (cycle %0d)", cyc);
        end else begin
          e = q2_exp.pop_front();
          check("q2_result", q2_result, e.word);
          if (e.due >= 0) check("q2_ready_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  logic [31:0] pool [4];
  logic [31:0] addr;
  int          issued;
  logic        drop1, drop2;
  int          t;

  initial begin
    pool = '{32'h0000_0100, 32'h0000_0104, 32'h0000_2000, 32'hFFFF_FFF8};
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    q1_valid = 1'b0; q2_valid = 1'b0; q1_addr = '0; q2_addr = '0;
    repeat (2) tick();
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_q1_ready", {31'd0, q1_ready}, 32'd0);
    check("reset_q2_ready", {31'd0, q2_ready}, 32'd0);
    check("reset_q1_result", q1_result, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    // T1: single fill, latency and address sequence
    tick();
    q1_valid = 1'b1; q1_addr = 32'h100; push(1, 32'h100, cyc + 6);
    check("t1_word_model", ref_word(32'h100), 32'h4433_2211);
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 7) q1_valid = 1'b0;
      #1;
      if (n <= 4) check("t1_mem_a", mem_a, 32'h100 + 32'(n - 1));
    end

    // T2: simultaneous requests, q1 priority
    tick();
    q1_valid = 1'b1; q1_addr = 32'h102; q2_valid = 1'b1; q2_addr = 32'h104;
    push(1, 32'h100, cyc + 6); push(2, 32'h104, cyc + 13);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 7)  q1_valid = 1'b0;
      if (n == 14) q2_valid = 1'b0;
      #1;
      if (n == 1) check("t2_mem_a_q1", mem_a, 32'h100);
      if (n == 8) check("t2_mem_a_q2", mem_a, 32'h104);
    end

    // T3: flush mid-read, then a fresh request
    tick();
    q1_valid = 1'b1; q1_addr = 32'h200;
    tick(); tick();
    tick(); rob_clear = 1'b1; q1_valid = 1'b0;
    tick(); rob_clear = 1'b0;
    q1_valid = 1'b1; q1_addr = 32'h204; push(1, 32'h204, cyc + 6);
    #1 check("t3_idle_mem_a", mem_a, 32'd0);
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 7) q1_valid = 1'b0;
      #1;
      if (n == 1) check("t3_mem_a_new", mem_a, 32'h204);
    end

    // T4: stall in cycles 2-4, byte0 re-read on resume
    tick();
    q1_valid = 1'b1; q1_addr = 32'h300; push(1, 32'h300, cyc + 10);
    for (int n = 1; n <= 11; n++) begin
      tick();
      rdy_in = !(n >= 2 && n <= 4);
      if (n == 11) q1_valid = 1'b0;
      #1;
      if (n >= 2 && n <= 5) check("t4_mem_a_hold", mem_a, 32'h300);
      if (n >= 6 && n <= 8) check("t4_mem_a_resume", mem_a, 32'h300 + 32'(n - 5));
    end

    // T5: asynchronous reset mid-read
    tick();
    q1_valid = 1'b1; q1_addr = 32'h400;
    tick(); tick();
    #2 rst_n_in = 1'b0; q1_valid = 1'b0;
    #1;
    check("t5_mem_a", mem_a, 32'd0);
    check("t5_q1_ready", {31'd0, q1_ready}, 32'd0);
    check("t5_q1_result", q1_result, 32'd0);
    check("t5_q2_result", q2_result, 32'd0);
    #3 rst_n_in = 1'b1;
    tick();

    // T6: repeat of an already-fetched word on q2
    tick();
    q1_valid = 1'b1; q1_addr = 32'h100; push(1, 32'h100, cyc + 6);
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 7) q1_valid = 1'b0;
    end
    tick();
    q2_valid = 1'b1; q2_addr = 32'h102; push(2, 32'h100, cyc + HIT_LAT);
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == HIT_LAT + 1) q2_valid = 1'b0;
      #1;
      if (n == 1) check("t6_mem_a", mem_a, (HIT_LAT == 1) ? 32'd0 : 32'h100);
    end

    // Randomized two-channel traffic with random stalls
    issued = 0; drop1 = 1'b0; drop2 = 1'b0;
    for (t = 0; t < 4000 && (issued < 60 || q1_valid || q2_valid); t++) begin
      tick();
      if (drop1) begin q1_valid = 1'b0; drop1 = 1'b0; end
      if (drop2) begin q2_valid = 1'b0; drop2 = 1'b0; end
      rdy_in = ($urandom_range(0, 7) != 0);
      for (int ch = 1; ch <= 2; ch++) begin
        if (((ch == 1) ? !q1_valid : !q2_valid) && issued < 60 && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0:       addr = $urandom;
            1:       addr = pool[$urandom_range(0, 3)];
            2:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: addr = 32'h100 + 32'($urandom_range(0, 15));
          endcase
          if (ch == 1) begin q1_valid = 1'b1; q1_addr = addr; end
          else         begin q2_valid = 1'b1; q2_addr = addr; end
          push(ch, addr, -1);
          issued++;
        end
      end
      #1;
      if (q1_ready) drop1 = 1'b1;
      if (q2_ready) drop2 = 1'b1;
    end
    if (q1_valid || q2_valid) begin
      n_checks++; n_fail++;
      $display("FAIL random_timeout: got outstanding request after %0d cycles required none", t);
    end
    rdy_in = 1'b1; q1_valid = 1'b0; q2_valid = 1'b0;
    repeat (3) tick();
    check("q1_scoreboard_drained", 32'(q1_exp.size()), 32'd0);
    check("q2_scoreboard_drained", 32'(q2_exp.size()), 32'd0);
    check("mem_wr_low", {31'd0, mem_wr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
